sram_responder: RTL
===================

# sram_responder

SRAM-side responder for the address-decoded memory bus. It owns a synchronous RAM of 2^ADDR_BITS words. It accepts a request only while the active-low chip enable from the SRAM range decoder (0x0000–0x3FFF) is asserted. It then inserts a fixed number of wait states, performs the read or write, and returns a one-cycle `ready` pulse with read data to the bus initiator.

## Interface
- `N`, 16, bus address width
- `ADDR_BITS`, 14, RAM index width; depth = 2^ADDR_BITS words
- `DATA_W`, 8, data word width
- `WAIT_STATES`, 2, wait cycles between accept and transfer; legal range 0–15
- `clk`  in  1  system clock; all state updates on rising edge
- `RESET`  in  1  synchronous, active-high reset
- `CE`  in  1  active-low chip enable from the SRAM range decoder
- `req`  in  1  request strobe from the initiator; sampled only in IDLE
- `we`  in  1  1 = write, 0 = read; sampled with `req`
- `address`  in  N  bus address; only bits [ADDR_BITS-1:0] are used
- `wdata`  in  DATA_W  write data; sampled with `req`
- `rdata`  out  DATA_W  read data; registered
- `ready`  out  1  one-cycle completion pulse; registered
- `busy`  out  1  high whenever the state is not IDLE

## Operation
- States: IDLE, WAIT, XFER.
- **IDLE**
  - If `req`=1 and `CE`=0 on an edge, the block accepts the request.
  - On accept it latches `address[ADDR_BITS-1:0]`, `we` and `wdata`.
  - If `WAIT_STATES`=0, it goes to XFER. Otherwise it goes to WAIT with the counter set to WAIT_STATES-1.
  - If `req`=1 and `CE`=1, the request is not for this chip. It is ignored: no state change and no `ready`.
- **WAIT**
  - On each edge: if the counter is 0, go to XFER; otherwise decrement the counter.
  - WAIT lasts exactly WAIT_STATES cycles.
- **XFER**
  - Write: the RAM at the latched index is written with the latched `wdata`. `rdata` is unchanged.
  - Read: `rdata` is loaded with the RAM at the latched index.
  - Read or write: `ready` is set to 1 and the state returns to IDLE.
- `ready` is cleared on every edge where the state is not XFER, so it is exactly one cycle wide.
- Inputs are sampled only at accept. Changes to `req`, `CE`, `we`, `address` or `wdata` while `busy` is high have no effect on the transaction in flight.
- A `req` held high while `busy` is high is not queued. The initiator must re-present it.
- Address bits [N-1:ADDR_BITS] are ignored, so the index wraps within the RAM. Range checking is the decoder's job.
- Reset:
  - Forces IDLE, counter=0, `ready`=0, `rdata`=0.
  - RAM contents are not cleared.
  - A reset asserted before the XFER edge aborts the transaction: no RAM write and no `ready`.
  - If `RESET` and an XFER edge coincide, reset wins and no write occurs.

## Timing
- Accept at edge E0. XFER edge is E0+WAIT_STATES+1.
- `ready` and the new `rdata` are visible in the cycle after the XFER edge, i.e. WAIT_STATES+2 cycles after `req` is first presented in IDLE.
- `busy` is combinational from state. It rises in the cycle after E0 and falls in the cycle where `ready` is high.
- Back-to-back transfers: a new request presented in the cycle where `ready`=1 is accepted on that edge (state is IDLE). Sustained throughput is one transfer per WAIT_STATES+2 cycles.
- Read-after-write to the same index returns the new data. The write commits at its XFER edge, before any later accept.
- `rdata` holds its value until the next read's XFER edge.

## Test plan
- **Reset values:** assert `RESET` for 2 cycles → `ready`=0, `busy`=0, `rdata`=0x00 in the cycle after release.
- **Write then read, WAIT_STATES=2:**
  - Write 0xA5 to 0x0123 → `ready` pulses exactly 4 cycles after `req` is presented and stays high for one cycle.
  - Read 0x0123 → `rdata`=0xA5 with `ready`, and `rdata` holds 0xA5 afterwards.
- **Not selected:** `req`=1, `CE`=1, `address`=0x4000 held for 10 cycles → `busy` stays 0, `ready` never pulses, RAM unchanged. A subsequent read of 0x0000 returns the prior value.
- **Mid-transaction changes:**
  - Accept a write of 0x3C to 0x0010.
  - In the next cycle drive `address`=0x0020, `wdata`=0xFF, `CE`=1.
  - Required: the read of 0x0010 returns 0x3C, and the read of 0x0020 is unchanged.
- **Reset mid-transfer:**
  - Accept a write of 0x77 to 0x0005.
  - Assert `RESET` during WAIT.
  - Required: no `ready`, state returns to IDLE, and a read of 0x0005 returns the old value.
- **Back-to-back and wrap:**
  - With WAIT_STATES=0, present a read in the `ready` cycle of the previous transfer → accepted, with `ready` pulses 2 cycles apart.
  - Write 0x11 to 0x3FFF, then read 0x7FFF (wraps to index 0x3FFF) → 0x11.

Source files
------------

// File: rtl/sram_responder.sv
// sram_responder: wait-stated synchronous SRAM slave on the decoded memory bus.
// Requests are latched on accept; ready pulses one cycle after the XFER edge.
module sram_responder #(
  parameter int N           = 16,
  parameter int ADDR_BITS   = 14,
  parameter int DATA_W      = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              CE,
  input  logic              req,
  input  logic              we,
  input  logic [N-1:0]      address,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, WAIT, XFER} state_t;
  state_t              state_q;
  logic [3:0]          cnt_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic                we_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                ready_q;
  logic [DATA_W-1:0]   mem [2**ADDR_BITS];
  logic                unused_addr;
  assign unused_addr = ^address[N-1:ADDR_BITS];
  assign busy  = state_q != IDLE;
  assign rdata = rdata_q;
  assign ready = ready_q;
  // RAM has no reset; a coinciding reset still blocks the write.
  always_ff @(posedge clk)
    if (!RESET && state_q == XFER && we_q) mem[addr_q] <= wdata_q;
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= state_q == XFER;
      case (state_q)
        IDLE: if (req && !CE) begin
          addr_q  <= address[ADDR_BITS-1:0];
          we_q    <= we;
          wdata_q <= wdata;
          state_q <= WAIT_STATES == 0 ? XFER : WAIT;
          cnt_q   <= WAIT_STATES == 0 ? 4'd0 : 4'(WAIT_STATES - 1);
        end
        WAIT: if (cnt_q == '0) state_q <= XFER; else cnt_q <= cnt_q - 4'd1;
        XFER: begin
          if (!we_q) rdata_q <= mem[addr_q];
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
